round_key_buf: RTL and testbench
================================

Name: round_key_buf

Overview:
- Round-key buffer directly upstream of the round-function datapath; drives its 128-bit RKI input.
- Accepts a burst of pre-expanded round keys from the key loader over a valid/ready handshake and stores them in a register file.
- Once locked, presents the key for the current outer_round, in forward order for encryption and reverse order for decryption, with one cycle of registered latency.

Parameters:
- NUM_RK, 16, number of round-key slots (max keys per schedule).
- KW, 128, round-key width in bits.
- AW, 4, slot index width; must satisfy 2^AW >= NUM_RK.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous flush: empties buffer, returns to EMPTY.
- rk_in  in  KW  round key word from key loader.
- rk_in_valid  in  1  rk_in is valid.
- rk_in_last  in  1  marks final key of the schedule; qualified by rk_in_valid.
- rk_in_ready  out  1  buffer can accept rk_in this cycle.
- mode_enc_dec  in  1  1 = encrypt (forward order), 0 = decrypt (reverse order).
- outer_round  in  4  current round index from the round controller.
- RKI  out  KW  registered round key for the round datapath.
- rk_valid  out  1  RKI corresponds to the current locked schedule.
- count  out  AW+1  number of stored keys.
- full  out  1  count == NUM_RK.
- err_range  out  1  sticky: outer_round >= count was sampled while LOCKED.

Behaviour:
- Reset (rst=1, asynchronous) sets the following registered outputs/state:
  - state=EMPTY, count=0, RKI=0, rk_valid=0, err_range=0.
  - Slot storage is not reset.
- Clock and reset naming: one clock clk. Reset rst is asynchronous and active-high. No other clocks or resets.
- States and transitions:
  - EMPTY: rk_in_ready=1. An accepted word moves to FILL, or straight to LOCKED if rk_in_last=1.
  - FILL: rk_in_ready = (count < NUM_RK). Each accepted word goes to FILL or LOCKED using the rules below.
  - LOCKED: rk_in_ready=0; input words are ignored. Leaves only on clear or rst.
- Accept rule: a transfer happens when rk_in_valid && rk_in_ready at a rising edge.
  - The word is written to slot[count] and count increments by 1.
  - If rk_in_last=1, or the new count equals NUM_RK, the next state is LOCKED. Otherwise the next state is FILL.
- Full: full = (count == NUM_RK). When full is reached without rk_in_last, the buffer locks anyway; the last flag is then not required.
- Read path (LOCKED only), evaluated every cycle:
  - idx = outer_round when mode_enc_dec=1.
  - idx = count-1-outer_round when mode_enc_dec=0 (arithmetic in AW+1 bits).
  - If outer_round < count: RKI <= slot[idx] and rk_valid <= 1.
  - Otherwise: RKI <= 0, rk_valid <= 0, and err_range <= 1.
- Latency: a change of outer_round or mode_enc_dec at edge N is reflected on RKI after edge N+1.
- rk_valid first rises on the edge after the state enters LOCKED. It is 0 in EMPTY and FILL, and RKI holds 0 in those states.
- clear:
  - Next state is EMPTY; count, RKI, rk_valid and err_range go to 0.
  - clear has priority over a simultaneous accepted transfer: that word is dropped and count does not increment.
  - rk_in_ready is not gated by clear; the loader must not rely on a transfer during clear.
- err_range clears only on clear or rst.
- rk_in_last with rk_in_valid=0 has no effect.
- Reset asserted mid-fill or mid-round aborts immediately. The loader must reload after reset release.

Test Plan:
- Fill/lock, encrypt: load 11 keys 0x..00 through 0x..0A, last flag on the 11th. Expect count=11, rk_in_ready=0 after the 11th accept, rk_valid=1 one cycle later. Sweep outer_round 0..10 with mode_enc_dec=1; RKI matches key[outer_round] one cycle after each change.
- Decrypt order: same schedule, mode_enc_dec=0, outer_round=0. Expect RKI=key[10]. outer_round=10 gives RKI=key[0].
- Full without last: feed 16 keys with rk_in_last=0. Expect full=1, state LOCKED, and a 17th word with rk_in_valid=1 is ignored (count stays 16).
- Handshake stall: toggle rk_in_valid 1/0 every cycle for 4 words, then last. Expect count=5, with no duplicates or drops versus the sent sequence.
- Range error: lock with 10 keys, drive outer_round=12. Expect RKI=0, rk_valid=0, err_range=1 next cycle. err_range stays 1 after outer_round returns to 3, while RKI=key[3] and rk_valid=1.
- Clear/reset priority: assert clear together with a valid transfer in FILL. Expect count=0, state EMPTY, word dropped. Assert rst mid-LOCKED: RKI=0 and rk_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/round_key_buf.sv
// Round-key buffer: loads a pre-expanded key schedule over valid/ready,
// locks it, then serves the key for the current round in either order.
module round_key_buf #(
    parameter int NUM_RK = 16,
    parameter int KW     = 128,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [KW-1:0] rk_in,
    input  logic          rk_in_valid,
    input  logic          rk_in_last,
    output logic          rk_in_ready,
    input  logic          mode_enc_dec,
    input  logic [3:0]    outer_round,
    output logic [KW-1:0] RKI,
    output logic          rk_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err_range
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_LOCKED
    } state_t;

    localparam logic [AW:0] NUM_RK_W = (AW+1)'(NUM_RK);
    localparam logic [AW:0] ONE_W    = (AW+1)'(1);

    state_t          state;
    logic [KW-1:0]   slots [NUM_RK];
    logic            accept;
    logic [AW:0]     count_nxt;
    logic [AW:0]     round_ext;
    logic            in_range;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign accept    = rk_in_valid && rk_in_ready;
    assign count_nxt = count + ONE_W;
    assign round_ext = (AW+1)'(outer_round);
    assign in_range  = round_ext < count;
    assign wr_idx    = AW'(count);
    // Decrypt walks the schedule backwards from the last stored key.
    assign rd_idx    = mode_enc_dec ? AW'(round_ext)
                                    : AW'(count - ONE_W - round_ext);
    assign full      = (count == NUM_RK_W);

    // Loader may push while empty, or while filling and not yet full.
    always_comb begin
        rk_in_ready = 1'b0;
        unique case (state)
            ST_EMPTY:  rk_in_ready = 1'b1;
            ST_FILL:   rk_in_ready = (count < NUM_RK_W);
            ST_LOCKED: rk_in_ready = 1'b0;
            default:   rk_in_ready = 1'b0;
        endcase
    end

    // Key storage; deliberately not reset, a dropped word is never written.
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            slots[wr_idx] <= rk_in;
        end
    end

    // Fill/lock FSM, key count, registered read port and sticky range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            count     <= '0;
            RKI       <= '0;
            rk_valid  <= 1'b0;
            err_range <= 1'b0;
        end else if (clear) begin
            state     <= ST_EMPTY;
            count     <= '0;
            RKI       <= '0;
            rk_valid  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY, ST_FILL: begin
                    RKI      <= '0;
                    rk_valid <= 1'b0;
                    if (accept) begin
                        count <= count_nxt;
                        if (rk_in_last || count_nxt == NUM_RK_W) begin
                            state <= ST_LOCKED;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (in_range) begin
                        RKI      <= slots[rd_idx];
                        rk_valid <= 1'b1;
                    end else begin
                        RKI       <= '0;
                        rk_valid  <= 1'b0;
                        err_range <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_buf.sv
// Bench for round_key_buf: directed loads and reads, expectations queued
// by the stimulus and checked by an independent negedge monitor.
module tb_round_key_buf;

    logic         clk;
    logic         rst;
    logic         clear;
    logic [127:0] rk_in;
    logic         rk_in_valid;
    logic         rk_in_last;
    logic         rk_in_ready;
    logic         mode_enc_dec;
    logic [3:0]   outer_round;
    logic [127:0] RKI;
    logic         rk_valid;
    logic [4:0]   count;
    logic         full;
    logic         err_range;

    typedef struct {
        string        name;
        logic [127:0] rki;
        logic         v;
        logic         err;
        logic [4:0]   cnt;
        logic         full;
        logic         rdy;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_pass = 0;

    round_key_buf #(.NUM_RK(16), .KW(128), .AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .rk_in        (rk_in),
        .rk_in_valid  (rk_in_valid),
        .rk_in_last   (rk_in_last),
        .rk_in_ready  (rk_in_ready),
        .mode_enc_dec (mode_enc_dec),
        .outer_round  (outer_round),
        .RKI          (RKI),
        .rk_valid     (rk_valid),
        .count        (count),
        .full         (full),
        .err_range    (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] k(int s, int i);
        return {32'(s), 64'h0123_4567_89AB_CDEF, 32'(i)};
    endfunction

    task automatic chk(string nm, string fld, logic [127:0] act,
                       logic [127:0] want);
        n_chk++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, want);
        end
    endtask

    // Monitor: each negedge, compare outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk(cur.name, "RKI", RKI, cur.rki);
            chk(cur.name, "rk_valid", 128'(rk_valid), 128'(cur.v));
            chk(cur.name, "err_range", 128'(err_range), 128'(cur.err));
            chk(cur.name, "count", 128'(count), 128'(cur.cnt));
            chk(cur.name, "full", 128'(full), 128'(cur.full));
            chk(cur.name, "rk_in_ready", 128'(rk_in_ready), 128'(cur.rdy));
        end
    end

    task automatic expect_out(string nm, logic [127:0] r, logic v,
                              logic e, int c, logic f, logic rd);
        exp_t x;
        x.name = nm;
        x.rki  = r;
        x.v    = v;
        x.err  = e;
        x.cnt  = 5'(c);
        x.full = f;
        x.rdy  = rd;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [127:0] w, logic last);
        rk_in       = w;
        rk_in_valid = 1'b1;
        rk_in_last  = last;
        step();
        rk_in_valid = 1'b0;
        rk_in_last  = 1'b0;
    endtask

    task automatic do_clear(string nm);
        clear = 1'b1;
        step();
        clear = 1'b0;
        expect_out(nm, '0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        rk_in        = '0;
        rk_in_valid  = 1'b0;
        rk_in_last   = 1'b0;
        mode_enc_dec = 1'b1;
        outer_round  = 4'd0;
        repeat (2) step();
        expect_out("reset", '0, 0, 0, 0, 0, 1);
        step();
        rst = 1'b0;
        step();

        // 11-key schedule, encrypt sweep
        for (int i = 0; i < 10; i++) send(k(1, i), 1'b0);
        expect_out("fill10", '0, 0, 0, 10, 0, 1);
        send(k(1, 10), 1'b1);
        expect_out("lock11", '0, 0, 0, 11, 0, 0);
        step();
        expect_out("enc_r0", k(1, 0), 1, 0, 11, 0, 0);
        for (int r = 1; r <= 10; r++) begin
            outer_round = 4'(r);
            step();
            expect_out("enc_sweep", k(1, r), 1, 0, 11, 0, 0);
        end
        mode_enc_dec = 1'b0;
        outer_round  = 4'd0;
        step();
        expect_out("dec_r0", k(1, 10), 1, 0, 11, 0, 0);
        outer_round = 4'd10;
        step();
        expect_out("dec_r10", k(1, 0), 1, 0, 11, 0, 0);
        outer_round = 4'd5;
        step();
        expect_out("dec_r5", k(1, 5), 1, 0, 11, 0, 0);
        outer_round = 4'd11;
        step();
        expect_out("range_eq_cnt", '0, 0, 1, 11, 0, 0);
        do_clear("clear1");

        // full without last, extra word ignored
        mode_enc_dec = 1'b1;
        outer_round  = 4'd0;
        for (int i = 0; i < 16; i++) send(k(2, i), 1'b0);
        expect_out("full16", '0, 0, 0, 16, 1, 0);
        rk_in       = k(2, 99);
        rk_in_valid = 1'b1;
        step();
        rk_in_valid = 1'b0;
        expect_out("ignore17", k(2, 0), 1, 0, 16, 1, 0);
        outer_round = 4'd15;
        step();
        expect_out("full_r15", k(2, 15), 1, 0, 16, 1, 0);
        mode_enc_dec = 1'b0;
        step();
        expect_out("full_dec15", k(2, 0), 1, 0, 16, 1, 0);
        outer_round = 4'd0;
        step();
        expect_out("full_dec0", k(2, 15), 1, 0, 16, 1, 0);
        do_clear("clear2");

        // handshake stall: valid toggles each cycle
        mode_enc_dec = 1'b1;
        outer_round  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            rk_in       = k(3, i);
            rk_in_valid = 1'b1;
            step();
            rk_in_valid = 1'b0;
            rk_in       = k(3, 8'hEE);
            rk_in_last  = 1'b1;
            step();
            rk_in_last  = 1'b0;
        end
        send(k(3, 4), 1'b1);
        expect_out("stall_lock", '0, 0, 0, 5, 0, 0);
        for (int r = 0; r < 5; r++) begin
            outer_round = 4'(r);
            step();
            expect_out("stall_rd", k(3, r), 1, 0, 5, 0, 0);
        end
        do_clear("clear3");

        // range error is sticky
        outer_round = 4'd0;
        for (int i = 0; i < 9; i++) send(k(4, i), 1'b0);
        send(k(4, 9), 1'b1);
        expect_out("rng_lock", '0, 0, 0, 10, 0, 0);
        outer_round = 4'd12;
        step();
        expect_out("rng_err", '0, 0, 1, 10, 0, 0);
        outer_round = 4'd3;
        step();
        expect_out("rng_sticky", k(4, 3), 1, 1, 10, 0, 0);
        outer_round = 4'd9;
        step();
        expect_out("rng_edge", k(4, 9), 1, 1, 10, 0, 0);
        mode_enc_dec = 1'b0;
        step();
        expect_out("rng_dec9", k(4, 0), 1, 1, 10, 0, 0);
        do_clear("clear4");

        // clear beats a simultaneous transfer
        mode_enc_dec = 1'b1;
        outer_round  = 4'd0;
        send(k(5, 0), 1'b0);
        send(k(5, 1), 1'b0);
        expect_out("pre_clr", '0, 0, 0, 2, 0, 1);
        rk_in       = k(5, 2);
        rk_in_valid = 1'b1;
        clear       = 1'b1;
        step();
        rk_in_valid = 1'b0;
        clear       = 1'b0;
        expect_out("clr_drop", '0, 0, 0, 0, 0, 1);
        send(k(6, 0), 1'b1);
        expect_out("relock", '0, 0, 0, 1, 0, 0);
        step();
        expect_out("relock_rd", k(6, 0), 1, 0, 1, 0, 0);

        // async reset while locked, checked before any rising edge
        step();
        rst = 1'b1;
        expect_out("async_rst", '0, 0, 0, 0, 0, 1);
        step();
        rst = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
